// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file (Count, Compare, Status, Cause, EPC,
// Config, PRId) at the end of the pipeline. Takes the MEM/WB CP0 write and the
// MEM-stage exception info, serves mfc0 reads and raises the timer interrupt.
// Optional feature: define CP0_TIMER_INT_EN to build the Count/Compare timer
// interrupt; when undefined o_timer_int is tied low and Compare is plain storage.
module cp0_reg #(
  parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wen,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata,
  input  logic [5:0]  i_int,
  input  logic [31:0] i_excepttype,
  input  logic [31:0] i_current_inst_addr,
  input  logic        i_is_in_delayslot,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc,
  output logic [31:0] o_config,
  output logic [31:0] o_prid,
  output logic        o_timer_int
);

  typedef enum logic [4:0] {
    ADDR_COUNT   = 5'd9,
    ADDR_COMPARE = 5'd11,
    ADDR_STATUS  = 5'd12,
    ADDR_CAUSE   = 5'd13,
    ADDR_EPC     = 5'd14,
    ADDR_PRID    = 5'd15,
    ADDR_CONFIG  = 5'd16
  } cp0_addr_e;

  typedef enum logic [31:0] {
    EXC_NONE = 32'h0,
    EXC_INT  = 32'h1,
    EXC_SYS  = 32'h8,
    EXC_RI   = 32'ha,
    EXC_OV   = 32'hc,
    EXC_TR   = 32'hd,
    EXC_ERET = 32'he
  } exc_type_e;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        exc_take;
  logic        exc_eret;
  logic [4:0]  exc_code;

  assign wr_count   = i_wen && (i_waddr == ADDR_COUNT);
  assign wr_compare = i_wen && (i_waddr == ADDR_COMPARE);
  assign wr_status  = i_wen && (i_waddr == ADDR_STATUS);
  assign wr_cause   = i_wen && (i_waddr == ADDR_CAUSE);
  assign wr_epc     = i_wen && (i_waddr == ADDR_EPC);

  // Decode the MEM-stage exception into "take it" / "eret" and its ExcCode.
  always_comb begin
    exc_take = 1'b0;
    exc_eret = 1'b0;
    exc_code = '0;
    case (i_excepttype)
      EXC_INT:  begin exc_take = 1'b1; exc_code = 5'd0;  end
      EXC_SYS:  begin exc_take = 1'b1; exc_code = 5'd8;  end
      EXC_RI:   begin exc_take = 1'b1; exc_code = 5'd10; end
      EXC_OV:   begin exc_take = 1'b1; exc_code = 5'd12; end
      EXC_TR:   begin exc_take = 1'b1; exc_code = 5'd13; end
      EXC_ERET: exc_eret = 1'b1;
      default:  ;
    endcase
  end

  // Count: free-running increment, a software write replaces the increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      count_q <= '0;
    else if (wr_count) count_q <= i_wdata;
    else               count_q <= count_q + 32'd1;
  end

  // Compare: plain software-written register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        compare_q <= '0;
    else if (wr_compare) compare_q <= i_wdata;
  end

  // Status: software write, then EXL forced by exception entry / eret.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q <= 32'h1000_0000;
    end else begin
      if (wr_status) status_q <= i_wdata;
      if (exc_take)      status_q[1] <= 1'b1;
      else if (exc_eret) status_q[1] <= 1'b0;
    end
  end

  // Cause: IP[7:2] tracks i_int, software owns IP[1:0]/WP/IV, exceptions own BD/ExcCode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cause_q <= '0;
    end else begin
      cause_q[15:10] <= i_int;
      if (wr_cause) begin
        cause_q[9:8]   <= i_wdata[9:8];
        cause_q[23:22] <= i_wdata[23:22];
      end
      if (exc_take) begin
        cause_q[6:2] <= exc_code;
        if (!status_q[1]) cause_q[31] <= i_is_in_delayslot;
      end
    end
  end

  // EPC: exception entry with EXL clear overrides a same-cycle software write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      epc_q <= '0;
    end else if (exc_take && !status_q[1]) begin
      epc_q <= i_is_in_delayslot ? (i_current_inst_addr - 32'd4) : i_current_inst_addr;
    end else if (wr_epc) begin
      epc_q <= i_wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic timer_int_q;

  // Timer: sticky set on Count==Compare (Compare nonzero); a Compare write clears and wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                       timer_int_q <= 1'b0;
    else if (wr_compare)                                timer_int_q <= 1'b0;
    else if ((count_q == compare_q) && (compare_q != '0)) timer_int_q <= 1'b1;
  end

  assign o_timer_int = timer_int_q;
`else
  assign o_timer_int = 1'b0;
`endif

  // mfc0 read port: no write bypass, unmapped addresses read as zero.
  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      ADDR_COUNT:   o_rdata = count_q;
      ADDR_COMPARE: o_rdata = compare_q;
      ADDR_STATUS:  o_rdata = status_q;
      ADDR_CAUSE:   o_rdata = cause_q;
      ADDR_EPC:     o_rdata = epc_q;
      ADDR_PRID:    o_rdata = PRID_VAL;
      ADDR_CONFIG:  o_rdata = CONFIG_VAL;
      default:      o_rdata = '0;
    endcase
  end

  assign o_count   = count_q;
  assign o_compare = compare_q;
  assign o_status  = status_q;
  assign o_cause   = cause_q;
  assign o_epc     = epc_q;
  assign o_config  = CONFIG_VAL;
  assign o_prid    = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed scenarios with literal expectations followed by random
// traffic; a behavioural model of the CP0 registers is checked every cycle.
module tb_cp0_reg;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_wen;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic [4:0]  i_raddr;
  logic [31:0] o_rdata;
  logic [5:0]  i_int;
  logic [31:0] i_excepttype;
  logic [31:0] i_current_inst_addr;
  logic        i_is_in_delayslot;
  logic [31:0] o_count, o_compare, o_status, o_cause, o_epc, o_config, o_prid;
  logic        o_timer_int;

`ifdef CP0_TIMER_INT_EN
  localparam logic TIMER_ON = 1'b1;
`else
  localparam logic TIMER_ON = 1'b0;
`endif

  cp0_reg #(
    .PRID_VAL  (32'h0048_0102),
    .CONFIG_VAL(32'h0000_8000)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_wen              (i_wen),
    .i_waddr            (i_waddr),
    .i_wdata            (i_wdata),
    .i_raddr            (i_raddr),
    .o_rdata            (o_rdata),
    .i_int              (i_int),
    .i_excepttype       (i_excepttype),
    .i_current_inst_addr(i_current_inst_addr),
    .i_is_in_delayslot  (i_is_in_delayslot),
    .o_count            (o_count),
    .o_compare          (o_compare),
    .o_status           (o_status),
    .o_cause            (o_cause),
    .o_epc              (o_epc),
    .o_config           (o_config),
    .o_prid             (o_prid),
    .o_timer_int        (o_timer_int)
  );

  always #5 i_clk = ~i_clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        tint;
  } model_t;

  model_t m;

  // -1: no exception, -2: eret, otherwise the ExcCode to record
  function automatic int exc_class(input logic [31:0] t);
    case (t)
      32'h1:   return 0;
      32'h8:   return 8;
      32'ha:   return 10;
      32'hc:   return 12;
      32'hd:   return 13;
      32'he:   return -2;
      default: return -1;
    endcase
  endfunction

  function automatic model_t model_step(input model_t s);
    model_t n;
    int     ec;
    n = s;
    n.count = s.count + 32'd1;
    n.tint  = TIMER_ON && (s.tint || (s.count == s.compare && s.compare != 32'd0));
    n.cause[15:10] = i_int;
    if (i_wen) begin
      case (i_waddr)
        5'd9:  n.count = i_wdata;
        5'd11: begin n.compare = i_wdata; n.tint = 1'b0; end
        5'd12: n.status = i_wdata;
        5'd13: n.cause = (n.cause & ~32'h00C0_0300) | (i_wdata & 32'h00C0_0300);
        5'd14: n.epc = i_wdata;
        default: ;
      endcase
    end
    ec = exc_class(i_excepttype);
    if (ec >= 0) begin
      if (s.status[1] == 1'b0) begin
        n.epc = i_is_in_delayslot ? i_current_inst_addr - 32'd4 : i_current_inst_addr;
        n.cause[31] = i_is_in_delayslot;
      end
      n.status[1]   = 1'b1;
      n.cause[6:2]  = ec[4:0];
    end else if (ec == -2) begin
      n.status[1] = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m.count;
      5'd11:   return m.compare;
      5'd12:   return m.status;
      5'd13:   return m.cause;
      5'd14:   return m.epc;
      5'd15:   return 32'h0048_0102;
      5'd16:   return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m <= '{count: 32'd0, compare: 32'd0, status: 32'h1000_0000,
                         cause: 32'd0, epc: 32'd0, tint: 1'b0};
    else          m <= model_step(m);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      cmp("count",   o_count,   m.count);
      cmp("compare", o_compare, m.compare);
      cmp("status",  o_status,  m.status);
      cmp("cause",   o_cause,   m.cause);
      cmp("epc",     o_epc,     m.epc);
      cmp("config",  o_config,  32'h0000_8000);
      cmp("prid",    o_prid,    32'h0048_0102);
      cmp("timer",   {31'd0, o_timer_int}, {31'd0, m.tint});
      cmp("rdata",   o_rdata,   model_read(i_raddr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    i_wen = 1'b0;
    i_waddr = '0;
    i_wdata = '0;
    i_raddr = 5'd9;
    i_int = '0;
    i_excepttype = '0;
    i_current_inst_addr = '0;
    i_is_in_delayslot = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    i_wen = 1'b1;
    i_waddr = a;
    i_wdata = d;
  endtask

  task automatic drive_random();
    int unsigned r;
    i_wen = ($urandom_range(0, 2) == 0);
    r = $urandom_range(0, 9);
    case (r)
      0: i_waddr = 5'd9;
      1: i_waddr = 5'd11;
      2: i_waddr = 5'd12;
      3: i_waddr = 5'd13;
      4: i_waddr = 5'd14;
      5: i_waddr = 5'd15;
      6: i_waddr = 5'd16;
      default: i_waddr = 5'($urandom_range(0, 31));
    endcase
    i_wdata = $urandom();
    if (i_waddr == 5'd11 && $urandom_range(0, 1) == 1)
      i_wdata = m.count + 32'($urandom_range(2, 10));
    r = $urandom_range(0, 15);
    case (r)
      8:  i_excepttype = 32'h1;
      9:  i_excepttype = 32'h8;
      10: i_excepttype = 32'ha;
      11: i_excepttype = 32'hc;
      12: i_excepttype = 32'hd;
      13: i_excepttype = 32'he;
      14: i_excepttype = $urandom();
      15: i_excepttype = 32'h9;
      default: i_excepttype = 32'h0;
    endcase
    i_current_inst_addr = $urandom() & 32'hFFFF_FFFC;
    i_is_in_delayslot = 1'($urandom_range(0, 1));
    i_int = 6'($urandom_range(0, 63));
    i_raddr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(8, 17)) : 5'($urandom_range(0, 31));
  endtask

  initial begin
    idle();
    #2 i_rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    cmp("rst_count",  o_count, 32'd0);
    cmp("rst_status", o_status, 32'h1000_0000);
    cmp("rst_timer",  {31'd0, o_timer_int}, 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // 10 idle cycles after reset
    repeat (10) tick();
    cmp("idle_count",  o_count, 32'd10);
    cmp("idle_status", o_status, 32'h1000_0000);
    cmp("idle_prid",   o_prid, 32'h0048_0102);
    cmp("idle_timer",  {31'd0, o_timer_int}, 32'd0);

    // Count write and wrap
    wr(5'd9, 32'hFFFF_FFFE);
    tick(); idle();
    cmp("cnt_write", o_count, 32'hFFFF_FFFE);
    tick();
    cmp("cnt_ffff", o_count, 32'hFFFF_FFFF);
    tick();
    cmp("cnt_wrap", o_count, 32'd0);

    // Timer: Compare=20, Count=15
    wr(5'd11, 32'd20);
    tick();
    wr(5'd9, 32'd15);
    tick(); idle();
    repeat (5) tick();
    cmp("tmr_cnt20", o_count, 32'd20);
    cmp("tmr_pre",   {31'd0, o_timer_int}, 32'd0);
    tick();
    cmp("tmr_rise",  {31'd0, o_timer_int}, {31'd0, TIMER_ON});
    tick();
    cmp("tmr_hold",  {31'd0, o_timer_int}, {31'd0, TIMER_ON});
    wr(5'd11, 32'd0);
    tick(); idle();
    cmp("tmr_clear", {31'd0, o_timer_int}, 32'd0);

    // Exception 0x8 in delay slot, repeat with EXL set, then eret
    i_excepttype = 32'h8; i_current_inst_addr = 32'h0000_0100; i_is_in_delayslot = 1'b1;
    tick(); idle();
    cmp("exc_epc",  o_epc, 32'h0000_00FC);
    cmp("exc_bd",   {31'd0, o_cause[31]}, 32'd1);
    cmp("exc_code", {27'd0, o_cause[6:2]}, 32'd8);
    cmp("exc_exl",  {31'd0, o_status[1]}, 32'd1);
    i_excepttype = 32'h8; i_current_inst_addr = 32'h0000_0200;
    tick(); idle();
    cmp("exc2_epc",  o_epc, 32'h0000_00FC);
    cmp("exc2_code", {27'd0, o_cause[6:2]}, 32'd8);
    i_excepttype = 32'he;
    tick(); idle();
    cmp("eret_exl", {31'd0, o_status[1]}, 32'd0);

    // Cause write mask and IP sampling, from a clean reset
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wr(5'd13, 32'hFFFF_FFFF);
    tick(); idle();
    cmp("cause_mask", o_cause, 32'h00C0_0300);
    i_int = 6'b000001;
    tick();
    cmp("cause_ip2", {31'd0, o_cause[10]}, 32'd1);
    idle();

    // Same-cycle Status write and overflow exception
    wr(5'd12, 32'h0000_0000);
    i_excepttype = 32'hc;
    tick(); idle();
    cmp("st_exc_status", o_status, 32'h0000_0002);
    cmp("st_exc_code",   {27'd0, o_cause[6:2]}, 32'd12);
    i_raddr = 5'd3;
    #1 cmp("rd_unmapped", o_rdata, 32'd0);
    i_raddr = 5'd15;
    #1 cmp("rd_prid", o_rdata, 32'h0048_0102);
    i_raddr = 5'd16;
    #1 cmp("rd_config", o_rdata, 32'h0000_8000);

    // Random traffic with two mid-run resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      i_rst_n = !(i == 1000 || i == 2200);
      drive_random();
    end
    tick();
    i_rst_n = 1'b1;
    idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file at the end of the pipeline.
- Consumes the CP0 write triplet from the MEM/WB register: wen, waddr, wdata.
- Consumes exception info from the MEM stage.
- Holds Count, Compare, Status, Cause, EPC, Config and PRId, and raises the timer interrupt.
- Feeds the EX stage (mfc0 reads) and the exception control logic.

Parameters:
- PRID_VAL, 32'h0048_0102, read-only processor ID value.
- CONFIG_VAL, 32'h0000_8000, read-only Config value (BE=1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous reset, active-low
- i_wen  in  1  CP0 write enable, from MEM/WB
- i_waddr  in  5  CP0 write address
- i_wdata  in  32  CP0 write data
- i_raddr  in  5  CP0 read address (mfc0)
- o_rdata  out  32  CP0 read data, combinational
- i_int  in  6  external hardware interrupts
- i_excepttype  in  32  exception code from the MEM stage; 0 = none
- i_current_inst_addr  in  32  PC of the excepting instruction
- i_is_in_delayslot  in  1  excepting instruction is in a delay slot
- o_count  out  32  Count (reg 9)
- o_compare  out  32  Compare (reg 11)
- o_status  out  32  Status (reg 12)
- o_cause  out  32  Cause (reg 13)
- o_epc  out  32  EPC (reg 14)
- o_config  out  32  Config (reg 16)
- o_prid  out  32  PRId (reg 15)
- o_timer_int  out  1  timer interrupt, level, sticky

Behaviour:
- Clock and reset: i_rst_n is asynchronous, active-low; i_clk is the clock.
- Reset values:
  - count, compare, cause, epc = 0
  - status = 32'h1000_0000 (CU0=1)
  - o_timer_int = 0
  - config = CONFIG_VAL; prid = PRID_VAL. Both are constant at all times.
- Count:
  - Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
  - A write to reg 9 takes priority over the increment: the next value is i_wdata, not i_wdata+1.
- Cause IP[7:2] (bits 15:10): sampled from i_int every cycle, 1-cycle latency. Not writable by software.
- Writes: registered, visible on outputs the next cycle.
  - reg 9 Count: full write.
  - reg 11 Compare: full write; also clears o_timer_int in the same edge.
  - reg 12 Status: full write.
  - reg 14 EPC: full write.
  - reg 13 Cause: only IP[1:0] (bits 9:8), WP (bit 22) and IV (bit 23) are written; other bits are kept.
  - Regs 15 and 16 and unmapped addresses: write ignored.
- Read:
  - o_rdata = register selected by i_raddr.
  - Unmapped address returns 0.
  - No internal write-to-read bypass; forwarding is done in EX.
- Exceptions (i_excepttype != 0):
  - Processed on the same edge as any write. Exception-updated fields override the write.
  - For codes 0x1 (interrupt), 0x8 (syscall), 0xa (reserved instruction), 0xc (overflow), 0xd (trap):
    - If status[1] (EXL) == 0: epc <= i_current_inst_addr - 4 if i_is_in_delayslot, else i_current_inst_addr; cause[31] (BD) <= i_is_in_delayslot.
    - If EXL == 1: EPC and BD are unchanged.
    - Always: status[1] <= 1; cause[6:2] <= ExcCode (0x1->0, 0x8->8, 0xa->10, 0xc->12, 0xd->13).
  - Code 0xe (eret): status[1] <= 0; nothing else changes.
  - Any other nonzero code: ignored.
- Timer:
  - o_timer_int <= 1 on the edge after count == compare with compare != 0.
  - Stays 1 until Compare is written.
  - Compare write and match in the same cycle: the write wins; result is 0.
- Reset mid-operation: all state returns immediately to the reset values, including Count.

Optional Feature:
- Macro: CP0_TIMER_INT_EN.
- Defined: timer compare logic as above.
- Undefined:
  - o_timer_int is tied to 0 and there is no compare logic.
  - Compare is still readable and writable.
  - Count still increments.

Test Plan:
- Reset, then 10 idle cycles -> o_count = 10; o_status = 32'h1000_0000; o_prid = 32'h0048_0102; o_timer_int = 0.
- Write Count = 32'hFFFF_FFFE, then idle 2 cycles -> o_count reads FFFF_FFFE, then FFFF_FFFF, then 0 (wrap).
- Write Compare = 20, Count = 15 -> o_timer_int rises on the edge after count==20 and stays high; write Compare = 0 -> o_timer_int = 0 the next cycle.
- Exception 0x8 with PC = 32'h0000_0100, delay slot = 1, EXL = 0 -> epc = 32'h0000_00FC, cause[31] = 1, cause[6:2] = 8, status[1] = 1. A second 0x8 at PC 0x200 -> epc unchanged, ExcCode still 8. Then eret (0xe) -> status[1] = 0.
- Write Cause = 32'hFFFF_FFFF with i_int = 6'b000000 -> o_cause = 32'h00C0_0300. Drive i_int = 6'b000001 -> cause[10] = 1 one cycle later.
- Same-cycle Status write 32'h0000_0000 and exception 0xc -> status = 32'h0000_0002 and ExcCode = 12. Read i_raddr = 5'd3 -> o_rdata = 0.
